// File: rtl/opl3_pkg.sv
// Shared definitions for the OPL3 AXI4-Lite register bridge: register map,
// STATUS bit layout and the queued OPL3 write entry.
package opl3_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_OPL3_WR = 2'd1;
    localparam logic [1:0] REG_SCRATCH = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int STAT_OVF_BIT   = 8;
    localparam int STAT_EMPTY_BIT = 9;
    localparam int STAT_FULL_BIT  = 10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic       bank;
        logic [7:0] reg_addr;
        logic [7:0] data;
    } opl3_wr_entry_t;

    function automatic logic [31:0] pack_status(input logic       full,
                                                input logic       empty,
                                                input logic       ovf,
                                                input logic [4:0] level);
        logic [31:0] s;
        s                 = '0;
        s[4:0]            = level;
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_EMPTY_BIT] = empty;
        s[STAT_FULL_BIT]  = full;
        return s;
    endfunction

endpackage

// File: rtl/opl3_wr_fifo.sv
// Synchronous FIFO of pending OPL3 register writes with occupancy reporting.
module opl3_wr_fifo
    import opl3_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  opl3_wr_entry_t             din_i,
    input  logic                       pop_i,
    output opl3_wr_entry_t             dout_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    opl3_wr_entry_t   mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rptr_q];

    // A push into a full queue is refused rather than overwriting the head.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (!do_push && do_pop) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/opl3_axi_reg_bridge.sv
// AXI4-Lite slave exposing CTRL/OPL3_WR/SCRATCH/STATUS and pacing queued
// register writes out to an OPL3 core with a minimum inter-write gap.
module opl3_axi_reg_bridge
    import opl3_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH         = 16,
    parameter int WR_GAP_CYCLES      = 32
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            opl3_wr_valid,
    input  logic                            opl3_wr_ready,
    output logic [8:0]                      opl3_wr_addr,
    output logic [7:0]                      opl3_wr_data
);
    localparam int GAP_W = (WR_GAP_CYCLES > 1) ? $clog2(WR_GAP_CYCLES) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                          awready_q, awready_d;
    logic                          bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d;
    logic                          arready_q, arready_d;
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                          ctrl_q, ctrl_d;
    logic [31:0]                   scratch_q, scratch_d;
    logic [16:0]                   wr_last_q, wr_last_d;
    logic                          ovf_q, ovf_d;
    logic [GAP_W-1:0]              gap_q, gap_d;
    logic                          hold_q, hold_d;

    logic                          wr_hs, rd_hs, push, pop, issue_valid;
    opl3_wr_entry_t                push_entry, head;
    logic [LVL_W-1:0]              fifo_level;
    logic                          fifo_full, fifo_empty;
    logic [31:0]                   status;
    logic                          unused_sig;

    assign unused_sig = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

    assign wr_hs  = awready_q && s00_axi_awvalid && s00_axi_wvalid;
    assign rd_hs  = arready_q && s00_axi_arvalid;
    assign status = pack_status(fifo_full, fifo_empty, ovf_q, 5'(fifo_level));

    assign push_entry = '{bank: s00_axi_wdata[16], reg_addr: s00_axi_wdata[15:8],
                          data: s00_axi_wdata[7:0]};

    // Once presented, a write stays up until taken even if CTRL[0] drops.
    assign issue_valid = !fifo_empty && (gap_q == '0) && (ctrl_q || hold_q);
    assign pop         = issue_valid && opl3_wr_ready;

    always_comb begin
        awready_d = s00_axi_awvalid && s00_axi_wvalid && !bvalid_q && !awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        arready_d = s00_axi_arvalid && !rvalid_q && !arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        wr_last_d = wr_last_q;
        ovf_d     = ovf_q;
        push      = 1'b0;

        if (bvalid_q && s00_axi_bready) bvalid_d = 1'b0;
        if (wr_hs) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (s00_axi_awaddr[3:2])
                REG_CTRL: if (s00_axi_wstrb[0]) ctrl_d = s00_axi_wdata[0];
                REG_OPL3_WR: begin
                    if (s00_axi_wstrb[2:0] != 3'b111) begin
                        bresp_d = RESP_SLVERR;
                    end else if (fifo_full) begin
                        bresp_d = RESP_SLVERR;
                        ovf_d   = 1'b1;
                    end else begin
                        push      = 1'b1;
                        wr_last_d = s00_axi_wdata[16:0];
                    end
                end
                REG_SCRATCH: begin
                    for (int b = 0; b < 4; b++) begin
                        if (s00_axi_wstrb[b]) scratch_d[8*b +: 8] = s00_axi_wdata[8*b +: 8];
                    end
                end
                default: if (s00_axi_wdata[STAT_OVF_BIT]) ovf_d = 1'b0;
            endcase
        end

        if (rvalid_q && s00_axi_rready) rvalid_d = 1'b0;
        if (rd_hs) begin
            rvalid_d = 1'b1;
            case (s00_axi_araddr[3:2])
                REG_CTRL:    rdata_d = {31'b0, ctrl_q};
                REG_OPL3_WR: rdata_d = {15'b0, wr_last_q};
                REG_SCRATCH: rdata_d = scratch_q;
                default:     rdata_d = status;
            endcase
        end
    end

    always_comb begin
        gap_d  = gap_q;
        hold_d = hold_q;
        if (pop) begin
            gap_d  = GAP_W'(WR_GAP_CYCLES - 1);
            hold_d = 1'b0;
        end else begin
            if (gap_q != '0) gap_d = gap_q - 1'b1;
            if (issue_valid) hold_d = 1'b1;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            ctrl_q    <= 1'b0;
            scratch_q <= '0;
            wr_last_q <= '0;
            ovf_q     <= 1'b0;
            gap_q     <= '0;
            hold_q    <= 1'b0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            wr_last_q <= wr_last_d;
            ovf_q     <= ovf_d;
            gap_q     <= gap_d;
            hold_q    <= hold_d;
        end
    end

    opl3_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (s00_axi_aclk),
        .rst_ni  (s00_axi_aresetn),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RESP_OKAY;
    assign opl3_wr_valid   = issue_valid;
    assign opl3_wr_addr    = issue_valid ? {head.bank, head.reg_addr} : 9'd0;
    assign opl3_wr_data    = issue_valid ? head.data : 8'd0;

endmodule
